barrel_shifter_pipe: RTL and testbench

- Parametrised, pipelined successor of the 4-bit combinational barrel shifter.
- Shifts or rotates a W-bit word by a run-time amount of 0..W-1 positions.
- Supports the same eight 3-bit operation codes, and registers the result through log2(W) stages.
- Uses a valid/ready handshake on both sides, so it drops in between a register file / ALU operand stage and a result bus that may stall.

---
 rtl/barrel_shifter_pipe.sv | 146 ++++++++++++++
 tb/tb_barrel_shifter_pipe.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/barrel_shifter_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : barrel_shifter_pipe
//  Purpose  : Pipelined W-bit shifter/rotator, one stage per shift-amount
//             bit, with a valid/ready handshake and a global stall.
//  Options  : define BS_OVERFLOW_FLAG_EN to build the ovf output and its
//             overflow-tracking pipeline.
//  Revision : 1.0 - initial release
// ============================================================================
module barrel_shifter_pipe #(
    parameter int W  = 8,
    parameter int SW = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  E,
    input  logic [2:0]    cod,
    input  logic [SW-1:0] sh,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  S
`ifdef BS_OVERFLOW_FLAG_EN
    ,
    output logic          ovf
`endif
);

    localparam logic [2:0] c_op_dld = 3'b001;
    localparam logic [2:0] c_op_dli = 3'b010;
    localparam logic [2:0] c_op_rd  = 3'b011;
    localparam logic [2:0] c_op_dad = 3'b101;
    localparam logic [2:0] c_op_dai = 3'b110;
    localparam logic [2:0] c_op_ri  = 3'b111;

    // One stage's shift by a fixed power-of-two amount. Opcodes 000/100
    // fall through to the identity.
    function automatic logic [W-1:0] f_stage_shift(input logic [W-1:0] d,
                                                   input logic [2:0]   op,
                                                   input int           amt);
        logic [W-1:0] r;
        case (op)
            c_op_dld: r = d >> amt;
            c_op_dli: r = d << amt;
            c_op_rd:  r = (d >> amt) | (d << (W - amt));
            c_op_dad: r = $signed(d) >>> amt;
            c_op_dai: r = {d[W-1], d[W-2:0] << amt};
            c_op_ri:  r = (d << amt) | (d >> (W - amt));
            default:  r = d;
        endcase
        return r;
    endfunction

`ifdef BS_OVERFLOW_FLAG_EN
    // Overflow contributed by one stage. Because earlier stages already
    // shifted the word, the bits dropped here are exactly the next original
    // bits below those dropped before, so OR-ing stages gives the total.
    function automatic logic f_stage_ovf(input logic [W-1:0] d,
                                         input logic [2:0]   op,
                                         input int           amt);
        logic [W-2:0] low;
        logic         r;
        low = d[W-2:0] ^ {(W-1){d[W-1]}};
        case (op)
            c_op_dli: r = |(d >> (W - amt));
            c_op_dai: r = |(low >> (W - 1 - amt));
            default:  r = 1'b0;
        endcase
        return r;
    endfunction
`endif

    // Stage registers; index k holds the word after stage k.
    logic [SW-1:0]          r_vld;
    logic [SW-1:0][W-1:0]   r_data;
    logic [SW-1:0][2:0]     r_cod;
    logic [SW-1:0][SW-1:0]  r_sh;

    // Stage inputs: index 0 comes from the ports, index k from stage k-1.
    logic [SW-1:0]          w_in_vld;
    logic [SW-1:0][W-1:0]   w_in_data;
    logic [SW-1:0][2:0]     w_in_cod;
    logic [SW-1:0][SW-1:0]  w_in_sh;
    logic [SW-1:0][W-1:0]   w_nx_data;
    logic                   w_adv;
    logic                   w_unused;

    // The whole pipe advances unless a result is being held at the output.
    assign w_adv     = !(r_vld[SW-1] && !out_ready);
    assign in_ready  = w_adv;
    assign out_valid = r_vld[SW-1];
    assign S         = r_data[SW-1];

    assign w_in_vld  = {r_vld[SW-2:0], in_valid};
    assign w_in_data = {r_data[SW-2:0], E};
    assign w_in_cod  = {r_cod[SW-2:0], cod};
    assign w_in_sh   = {r_sh[SW-2:0], sh};

    // Opcode/amount bits beyond what each stage consumes are carried only
    // for simplicity of the pipeline shape.
    assign w_unused  = ^{r_cod[SW-1], r_sh[SW-1], w_in_sh};

`ifdef BS_OVERFLOW_FLAG_EN
    logic [SW-1:0] r_ovf;
    logic [SW-1:0] w_in_ovf;
    logic [SW-1:0] w_nx_ovf;

    assign w_in_ovf = {r_ovf[SW-2:0], 1'b0};
    assign ovf      = r_ovf[SW-1];
`endif

    for (genvar k = 0; k < SW; k++) begin : g_stage
        localparam int c_amt = 1 << k;
        assign w_nx_data[k] = w_in_sh[k][k]
                            ? f_stage_shift(w_in_data[k], w_in_cod[k], c_amt)
                            : w_in_data[k];
`ifdef BS_OVERFLOW_FLAG_EN
        assign w_nx_ovf[k]  = w_in_ovf[k]
                            | (w_in_sh[k][k] & f_stage_ovf(w_in_data[k], w_in_cod[k], c_amt));
`endif
    end

    // Pipeline registers: cleared asynchronously, frozen together on stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld  <= '0;
            r_data <= '0;
            r_cod  <= '0;
            r_sh   <= '0;
`ifdef BS_OVERFLOW_FLAG_EN
            r_ovf  <= '0;
`endif
        end else if (w_adv) begin
            r_vld  <= w_in_vld;
            r_data <= w_nx_data;
            r_cod  <= w_in_cod;
            r_sh   <= w_in_sh;
`ifdef BS_OVERFLOW_FLAG_EN
            r_ovf  <= w_nx_ovf;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_barrel_shifter_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_barrel_shifter_pipe
//  Purpose  : Self-checking bench for barrel_shifter_pipe (W = 8): vector
//             table, latency, back-pressure, random traffic, mid-stream reset.
//  Options  : BS_OVERFLOW_FLAG_EN enables the ovf checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_barrel_shifter_pipe;

    localparam int W  = 8;
    localparam int SW = 3;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  E;
    logic [2:0]    cod;
    logic [SW-1:0] sh;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  S;
`ifdef BS_OVERFLOW_FLAG_EN
    logic          ovf;
`endif

    barrel_shifter_pipe #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .E         (E),
        .cod       (cod),
        .sh        (sh),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S)
`ifdef BS_OVERFLOW_FLAG_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] s;
        logic       o;
    } exp_t;

    typedef struct {
        logic [7:0] e;
        logic [2:0] c;
        logic [2:0] n;
        logic [7:0] s;
        logic       o;
    } vec_t;

    exp_t sb[$];
    exp_t mon_x;
    vec_t tbl[23];
    int   checks   = 0;
    int   failures = 0;
    int   n_sent   = 0;
    int   n_recv   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Independent bit-level model using the full amount n at once.
    function automatic exp_t ref_op(input logic [7:0] e, input logic [2:0] c, input int n);
        exp_t r;
        r.s = e;
        r.o = 1'b0;
        for (int i = 0; i < 8; i++) begin
            case (c)
                3'd1: r.s[i] = (i + n < 8) ? e[(i + n) % 8] : 1'b0;
                3'd2: r.s[i] = (i >= n) ? e[(i - n + 8) % 8] : 1'b0;
                3'd3: r.s[i] = e[(i + n) % 8];
                3'd5: r.s[i] = (i + n < 8) ? e[(i + n) % 8] : e[7];
                3'd6: r.s[i] = (i == 7) ? e[7] : ((i >= n) ? e[(i - n + 8) % 8] : 1'b0);
                3'd7: r.s[i] = e[(i - n + 8) % 8];
                default: r.s[i] = e[i];
            endcase
        end
        if (c == 3'd2)
            for (int i = 8 - n; i <= 7; i++) if (e[i]) r.o = 1'b1;
        if (c == 3'd6)
            for (int i = 7 - n; i <= 6; i++) if (e[i] != e[7]) r.o = 1'b1;
        return r;
    endfunction

    // Scoreboard consumer: one pop per handshake on the output side.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result: got S=%b, expected no result", S);
            end else begin
                mon_x = sb.pop_front();
                chk("result_S", {24'd0, S}, {24'd0, mon_x.s});
`ifdef BS_OVERFLOW_FLAG_EN
                chk("result_ovf", {31'd0, ovf}, {31'd0, mon_x.o});
`endif
                n_recv++;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [7:0] e, input logic [2:0] c, input logic [2:0] n,
                        input logic [7:0] xs, input logic xo);
        exp_t x;
        int   t;
        x.s = xs;
        x.o = xo;
        in_valid = 1'b1;
        E = e;
        cod = c;
        sh = n;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("accept_in_time", {31'd0, in_ready}, 32'd1);
        if (in_ready) begin
            sb.push_back(x);
            n_sent++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_model(input logic [7:0] e, input logic [2:0] c, input logic [2:0] n);
        exp_t x;
        x = ref_op(e, c, int'(n));
        send(e, c, n, x.s, x.o);
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk(name, sb.size(), 0);
    endtask

    task automatic latency_test(input string name, input logic [7:0] e, input logic [2:0] c,
                                input logic [2:0] n);
        exp_t x;
        int   cnt;
        x = ref_op(e, c, int'(n));
        in_valid = 1'b1;
        E = e;
        cod = c;
        sh = n;
        #1;
        chk("latency_in_ready", {31'd0, in_ready}, 32'd1);
        sb.push_back(x);
        n_sent++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cnt = 1;
        while (!out_valid && cnt < 20) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk(name, cnt, SW);
        drain("latency_drain");
    endtask

    task automatic add_vec(input int i, input logic [7:0] e, input logic [2:0] c,
                           input logic [2:0] n, input logic [7:0] s, input logic o);
        tbl[i].e = e;
        tbl[i].c = c;
        tbl[i].n = n;
        tbl[i].s = s;
        tbl[i].o = o;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] held;
        int         t;
        bit         done;

        // Hand-derived expected results.
        add_vec( 0, 8'b10110110, 3'b001, 3'd3, 8'b00010110, 1'b0);
        add_vec( 1, 8'b10110110, 3'b011, 3'd3, 8'b11010110, 1'b0);
        add_vec( 2, 8'b10110110, 3'b111, 3'd1, 8'b01101101, 1'b0);
        add_vec( 3, 8'b10110110, 3'b101, 3'd2, 8'b11101101, 1'b0);
        add_vec( 4, 8'b10110110, 3'b010, 3'd2, 8'b11011000, 1'b1);
        add_vec( 5, 8'b11000011, 3'b110, 3'd2, 8'b10001100, 1'b1);
        add_vec( 6, 8'b11100001, 3'b110, 3'd2, 8'b10000100, 1'b0);
        add_vec( 7, 8'b01011010, 3'b000, 3'd5, 8'b01011010, 1'b0);
        add_vec( 8, 8'b01011010, 3'b100, 3'd5, 8'b01011010, 1'b0);
        for (int i = 0; i < 8; i++)
            add_vec(9 + i, 8'b10110110, 3'(i), 3'd0, 8'b10110110, 1'b0);
        add_vec(17, 8'b10000000, 3'b001, 3'd7, 8'b00000001, 1'b0);
        add_vec(18, 8'b10000000, 3'b101, 3'd7, 8'b11111111, 1'b0);
        add_vec(19, 8'b10000001, 3'b111, 3'd7, 8'b11000000, 1'b0);
        add_vec(20, 8'b00000001, 3'b010, 3'd7, 8'b10000000, 1'b0);
        add_vec(21, 8'b00000011, 3'b010, 3'd7, 8'b10000000, 1'b1);
        add_vec(22, 8'b00000001, 3'b110, 3'd7, 8'b00000000, 1'b1);

        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        E = '0;
        cod = '0;
        sh = '0;

        // Reset state, with a pending input that must be ignored.
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b1;
        E = 8'hFF;
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_S", {24'd0, S}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Vector table, streamed back to back.
        for (int i = 0; i < 23; i++)
            send(tbl[i].e, tbl[i].c, tbl[i].n, tbl[i].s, tbl[i].o);
        in_valid = 1'b0;
        drain("table_drain");

        latency_test("latency_dld", 8'b10110110, 3'b001, 3'd3);

        // Back-pressure: six ops, output stalled three cycles at first valid.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send_model(8'(8'h11 * (i + 1)), 3'(i + 1), 3'(i + 1));
                in_valid = 1'b0;
            end
            begin
                t = 0;
                while (!out_valid && t < 20) begin
                    @(posedge clk);
                    #1;
                    t++;
                end
                chk("stall_first_valid", {31'd0, out_valid}, 32'd1);
                out_ready = 1'b0;
                held = S;
                for (int j = 0; j < 3; j++) begin
                    @(negedge clk);
                    chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
                    chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
                    chk("stall_S_stable", {24'd0, S}, {24'd0, held});
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain("stall_drain");

        // Random traffic with random output back-pressure.
        fork
            begin
                for (int i = 0; i < 40; i++)
                    send_model(8'($urandom), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
                in_valid = 1'b0;
                done = 1'b1;
            end
            begin
                t = 0;
                while ((!done || sb.size() != 0) && t < 2000) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                    t++;
                end
                out_ready = 1'b1;
            end
        join
        drain("random_drain");

        // Mid-stream reset with results in flight.
        in_valid = 1'b1;
        cod = 3'b000;
        sh = 3'd0;
        E = 8'hA5;
        @(posedge clk);
        #1;
        E = 8'h5A;
        @(posedge clk);
        #1;
        E = 8'hC3;
        @(posedge clk);
        #1;
        chk("pre_reset_out_valid", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        E = 8'h77;
        #1;
        chk("midreset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midreset_S", {24'd0, S}, 32'd0);
        chk("midreset_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("held_reset_out_valid", {31'd0, out_valid}, 32'd0);
        end
        #3;
        rst_n = 1'b1;
        begin
            exp_t x;
            x = ref_op(8'h77, 3'b000, 0);
            sb.push_back(x);
            n_sent++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        t = 1;
        while (!out_valid && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("post_reset_latency", t, SW);
        chk("post_reset_S", {24'd0, S}, 32'h77);
        drain("post_reset_drain");

        repeat (5) @(posedge clk);
        #1;
        chk("final_sent_vs_recv", n_recv, n_sent);
        chk("final_queue_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
